ofmap_wb_ctrl: RTL and testbench

Writeback scheduler that sits between the accumulator array's quantized ofmap row output and the global buffer (GLB) write port. It stages incoming rows in a small buffer and generates linear GLB addresses. It issues valid/ready writes to the GLB, asserts backpressure to the systolic-array sequencer, and reports tile and layer completion.

---
 rtl/ofmap_wb_ctrl_pkg.sv | 29 ++
 rtl/ofmap_wb_ctrl_wb_row_fifo.sv | 66 ++++++
 rtl/ofmap_wb_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_ofmap_wb_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofmap_wb_ctrl_pkg.sv
// Shared definitions for the ofmap writeback controller: FSM encodings,
// default geometry, and a helper for sizing counters.
package ofmap_wb_ctrl_pkg;

    typedef logic [1:0] wb_state_t;

    localparam wb_state_t ST_IDLE  = 2'd0;
    localparam wb_state_t ST_RUN   = 2'd1;
    localparam wb_state_t ST_FLUSH = 2'd2;
    localparam wb_state_t ST_DONE  = 2'd3;

    localparam int PE_SIZE_DEF    = 14;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ROW_NUM_DEF    = 70;
    localparam int TILE_NUM_DEF   = 21;
    localparam int ADDR_WIDTH_DEF = 16;
    localparam int BUF_DEPTH_DEF  = 4;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_BITS    = DATA_WIDTH_DEF * PE_SIZE_DEF;
    localparam int ROW_CNT_W   = cnt_w(ROW_NUM_DEF);
    localparam int TILE_CNT_W  = cnt_w(TILE_NUM_DEF);
    localparam int BUF_CNT_W   = cnt_w(BUF_DEPTH_DEF) + 1;

endpackage

// File: rtl/ofmap_wb_ctrl_wb_row_fifo.sv
// Synchronous first-word-fall-through row FIFO. The head entry is always
// visible on dout; reset clears pointers and count, never the storage.
module wb_row_fifo #(
    parameter int WIDTH = 112,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Qualify requests: no pop when empty, push into a full FIFO only alongside a pop.
    always_comb begin
        w_do_pop  = pop & (r_count != '0);
        w_do_push = push & ((r_count != CNT_W'(DEPTH)) | w_do_pop);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Row storage; when full with a simultaneous pop the write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/ofmap_wb_ctrl.sv
// Ofmap writeback scheduler: stages quantized rows from the accumulator
// array and writes them to consecutive GLB addresses from a latched base.
// Optional per-tile completion pulse enabled by macro OFMAP_WB_TILE_IRQ_EN.
module ofmap_wb_ctrl
    import ofmap_wb_ctrl_pkg::*;
#(
    parameter int PE_SIZE    = PE_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ROW_NUM    = ROW_NUM_DEF,
    parameter int TILE_NUM   = TILE_NUM_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] ofmap_row_i,
    input  logic                          ofmap_valid_i,
    output logic                          stall_o,
    output logic                          glb_wr_en_o,
    input  logic                          glb_ready_i,
    output logic [ADDR_WIDTH-1:0]         glb_addr_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0] glb_wdata_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_overflow_o
`ifdef OFMAP_WB_TILE_IRQ_EN
    ,
    output logic                          tile_done_o
`endif
);
    localparam int RB     = DATA_WIDTH * PE_SIZE;
    localparam int ROW_W  = cnt_w(ROW_NUM);
    localparam int TILE_W = cnt_w(TILE_NUM);
    localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROW_NUM - 1);
    localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(TILE_NUM - 1);
    localparam logic [CNT_W-1:0]  STALL_TH  = CNT_W'(BUF_DEPTH - 1);

    wb_state_t         r_state;
    wb_state_t         w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ROW_W-1:0]  r_row_in;
    logic [TILE_W-1:0] r_tile_in;
    logic              r_stall;
    logic              r_err;

    logic              w_start;
    logic              w_xfer_phase;
    logic              w_wr_en;
    logic              w_pop;
    logic              w_accept;
    logic              w_push;
    logic              w_drop;
    logic              w_last_push;
    logic [CNT_W-1:0]  w_count_next;

    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [RB-1:0]     w_head;

    wb_row_fifo #(
        .WIDTH (RB),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (ofmap_row_i),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Handshake decode: who pushes, who pops, and whether a row is lost.
    always_comb begin
        w_start      = (r_state == ST_IDLE) & start_i;
        w_xfer_phase = (r_state == ST_RUN) | (r_state == ST_FLUSH);
        w_wr_en      = w_xfer_phase & ~w_empty;
        w_pop        = w_wr_en & glb_ready_i;
        w_accept     = (r_state == ST_RUN) & ofmap_valid_i;
        w_push       = w_accept & (~w_full | w_pop);
        w_drop       = w_accept & w_full & ~w_pop;
        w_last_push  = w_push & (r_row_in == ROW_LAST) & (r_tile_in == TILE_LAST);
        case ({w_push, w_pop})
            2'b10:   w_count_next = w_count + CNT_W'(1);
            2'b01:   w_count_next = w_count - CNT_W'(1);
            default: w_count_next = w_count;
        endcase
    end

    // Layer sequencing; FLUSH leaves as soon as the final transfer empties the buffer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last_push) begin
                    w_state_next = ST_FLUSH;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (w_count_next == '0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Input row/tile position, advanced on every accepted row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_in  <= '0;
            r_tile_in <= '0;
        end else if (w_start) begin
            r_row_in  <= '0;
            r_tile_in <= '0;
        end else if (w_push) begin
            if (r_row_in == ROW_LAST) begin
                r_row_in  <= '0;
                r_tile_in <= (r_tile_in == TILE_LAST) ? '0 : r_tile_in + TILE_W'(1);
            end else begin
                r_row_in  <= r_row_in + ROW_W'(1);
            end
        end
    end

    // Write address = base + completed transfers, wrapping at the address width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (w_start) begin
            r_addr <= base_addr_i;
        end else if (w_pop) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
        end
    end

    // Sticky overflow flag, cleared only by a new layer start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end
    end

    // Backpressure from next occupancy so the sequencer sees it one row early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= 1'b0;
        end else begin
            r_stall <= (w_state_next == ST_RUN) && (w_count_next >= STALL_TH);
        end
    end

`ifdef OFMAP_WB_TILE_IRQ_EN
    logic [ROW_W-1:0] r_out_row;
    logic             r_tile_done;

    // Count transferred rows within a tile and pulse once the tile's last row is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_row   <= '0;
            r_tile_done <= 1'b0;
        end else if (w_start) begin
            r_out_row   <= '0;
            r_tile_done <= 1'b0;
        end else if (w_pop) begin
            r_out_row   <= (r_out_row == ROW_LAST) ? '0 : r_out_row + ROW_W'(1);
            r_tile_done <= (r_out_row == ROW_LAST);
        end else begin
            r_tile_done <= 1'b0;
        end
    end

    assign tile_done_o = r_tile_done;
`endif

    // Output decode; write data is forced to zero whenever no write is offered.
    always_comb begin
        glb_wr_en_o    = w_wr_en;
        glb_addr_o     = r_addr;
        if (w_wr_en) begin
            glb_wdata_o = w_head;
        end else begin
            glb_wdata_o = '0;
        end
        busy_o         = w_xfer_phase;
        done_o         = (r_state == ST_DONE);
        stall_o        = r_stall;
        err_overflow_o = r_err;
    end

endmodule

// File: tb/tb_ofmap_wb_ctrl.sv
// Self-checking bench for ofmap_wb_ctrl with ROW_NUM=3, TILE_NUM=2, BUF_DEPTH=4.
module tb_ofmap_wb_ctrl;
    localparam int RB = 112;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic [15:0]     base_addr_i = 16'h0000;
    logic [RB-1:0]   ofmap_row_i = '0;
    logic            ofmap_valid_i = 1'b0;
    logic            stall_o;
    logic            glb_wr_en_o;
    logic            glb_ready_i = 1'b0;
    logic [15:0]     glb_addr_o;
    logic [RB-1:0]   glb_wdata_o;
    logic            busy_o;
    logic            done_o;
    logic            err_overflow_o;
`ifdef OFMAP_WB_TILE_IRQ_EN
    logic            tile_done_o;
    int              tile_cnt = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    ofmap_wb_ctrl #(
        .PE_SIZE(14), .DATA_WIDTH(8), .ROW_NUM(3), .TILE_NUM(2),
        .ADDR_WIDTH(16), .BUF_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .ofmap_row_i(ofmap_row_i), .ofmap_valid_i(ofmap_valid_i), .stall_o(stall_o),
        .glb_wr_en_o(glb_wr_en_o), .glb_ready_i(glb_ready_i), .glb_addr_o(glb_addr_o),
        .glb_wdata_o(glb_wdata_o), .busy_o(busy_o), .done_o(done_o),
        .err_overflow_o(err_overflow_o)
`ifdef OFMAP_WB_TILE_IRQ_EN
        , .tile_done_o(tile_done_o)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_o === 1'b1) done_cnt++;
`ifdef OFMAP_WB_TILE_IRQ_EN
        if (tile_done_o === 1'b1) tile_cnt++;
`endif
    end

    typedef struct {
        logic        start;
        logic [15:0] base;
        logic        valid;
        logic [7:0]  dbyte;
        logic        ready;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [7:0]  e_dbyte;
        logic        e_stall;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
        logic        e_td;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic s, input logic [15:0] b, input logic v,
                                input logic [7:0] d, input logic r, input logic ew,
                                input logic [15:0] ea, input logic [7:0] ed,
                                input logic es, input logic eb, input logic edn,
                                input logic ee, input logic et);
        vec_t x;
        x.start = s; x.base = b; x.valid = v; x.dbyte = d; x.ready = r;
        x.e_wr = ew; x.e_addr = ea; x.e_dbyte = ed; x.e_stall = es;
        x.e_busy = eb; x.e_done = edn; x.e_err = ee; x.e_td = et;
        return x;
    endfunction

    function automatic logic [RB-1:0] rowv(input logic [7:0] b);
        return {14{b}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_wr(input string nm, input logic [15:0] a, input logic [7:0] d);
        chk({nm, ".wr_en"}, glb_wr_en_o, 1'b1);
        chk({nm, ".addr"}, glb_addr_o, a);
        chk({nm, ".wdata"}, glb_wdata_o, rowv(d));
    endtask

    task automatic wait_done(input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen = 1'b1;
        end
        chk({nm, ".done_seen"}, seen, 1'b1);
    endtask

    task automatic push_row(input logic [7:0] d);
        ofmap_valid_i = 1'b1;
        ofmap_row_i   = rowv(d);
    endtask

    initial begin
        int snap;
        // Test 1 vectors: valid in IDLE, basic layer, start during RUN, valid in FLUSH.
        vecs[0]  = mk(0, 16'h0100, 1, 8'hAA, 1,  0, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 16'h0100, 0, 8'h00, 1,  0, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 16'h0100, 1, 8'h01, 1,  0, 16'h0100, 8'h00, 0, 1, 0, 0, 0);
        vecs[3]  = mk(0, 16'h0100, 1, 8'h02, 1,  1, 16'h0100, 8'h01, 0, 1, 0, 0, 0);
        vecs[4]  = mk(1, 16'h2222, 1, 8'h03, 1,  1, 16'h0101, 8'h02, 0, 1, 0, 0, 0);
        vecs[5]  = mk(0, 16'h0100, 1, 8'h04, 1,  1, 16'h0102, 8'h03, 0, 1, 0, 0, 0);
        vecs[6]  = mk(0, 16'h0100, 1, 8'h05, 1,  1, 16'h0103, 8'h04, 0, 1, 0, 0, 1);
        vecs[7]  = mk(0, 16'h0100, 1, 8'h06, 1,  1, 16'h0104, 8'h05, 0, 1, 0, 0, 0);
        vecs[8]  = mk(0, 16'h0100, 1, 8'hEE, 1,  1, 16'h0105, 8'h06, 0, 1, 0, 0, 0);
        vecs[9]  = mk(0, 16'h0100, 0, 8'h00, 1,  0, 16'h0106, 8'h00, 0, 0, 1, 0, 1);
        vecs[10] = mk(0, 16'h0100, 0, 8'h00, 1,  0, 16'h0106, 8'h00, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d.wr_en", i), glb_wr_en_o, vecs[i].e_wr);
            chk($sformatf("v%0d.addr", i), glb_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d.wdata", i), glb_wdata_o, rowv(vecs[i].e_dbyte));
            chk($sformatf("v%0d.stall", i), stall_o, vecs[i].e_stall);
            chk($sformatf("v%0d.busy", i), busy_o, vecs[i].e_busy);
            chk($sformatf("v%0d.done", i), done_o, vecs[i].e_done);
            chk($sformatf("v%0d.err", i), err_overflow_o, vecs[i].e_err);
`ifdef OFMAP_WB_TILE_IRQ_EN
            chk($sformatf("v%0d.tile_done", i), tile_done_o, vecs[i].e_td);
`endif
            start_i       = vecs[i].start;
            base_addr_i   = vecs[i].base;
            ofmap_valid_i = vecs[i].valid;
            ofmap_row_i   = rowv(vecs[i].dbyte);
            glb_ready_i   = vecs[i].ready;
        end

        // Test 2: backpressure with ready low, then in-order drain.
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 16'h0200; glb_ready_i = 1'b0; ofmap_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0; push_row(8'h11);
        @(negedge clk);
        chk_wr("bp1", 16'h0200, 8'h11); chk("bp1.stall", stall_o, 1'b0);
        push_row(8'h12);
        @(negedge clk);
        chk("bp2.stall", stall_o, 1'b0);
        push_row(8'h13);
        @(negedge clk);
        chk("bp3.stall", stall_o, 1'b1); chk_wr("bp3", 16'h0200, 8'h11);
        ofmap_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_hold.stall", stall_o, 1'b1);
            chk_wr("bp_hold", 16'h0200, 8'h11);
        end
        glb_ready_i = 1'b1;
        @(negedge clk);
        chk_wr("bp_drain1", 16'h0201, 8'h12); chk("bp_drain1.stall", stall_o, 1'b0);
        @(negedge clk);
        chk_wr("bp_drain2", 16'h0202, 8'h13);
        @(negedge clk);
        chk("bp_empty.wr_en", glb_wr_en_o, 1'b0); chk("bp_empty.busy", busy_o, 1'b1);
        push_row(8'h14);
        @(negedge clk);
        ofmap_valid_i = 1'b0; glb_ready_i = 1'b0;
        chk_wr("bp_pend", 16'h0203, 8'h14);

        // Test 5d: asynchronous reset mid-layer.
        snap = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.wr_en", glb_wr_en_o, 1'b0);
        chk("rst.addr", glb_addr_o, 16'h0000);
        chk("rst.wdata", glb_wdata_o, rowv(8'h00));
        chk("rst.busy", busy_o, 1'b0);
        chk("rst.stall", stall_o, 1'b0);
        chk("rst.err", err_overflow_o, 1'b0);
        chk("rst.done", done_o, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst.no_done", done_cnt, snap);
        rst_n = 1'b1;

        // Test 3: overflow with ready low, sticky flag, cleared by next start.
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 16'h0300; glb_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0; push_row(8'h21);
        @(negedge clk); push_row(8'h22);
        @(negedge clk); push_row(8'h23);
        @(negedge clk); push_row(8'h24);
        @(negedge clk);
        chk("ov_full.err", err_overflow_o, 1'b0); chk("ov_full.stall", stall_o, 1'b1);
        push_row(8'h25);
        @(negedge clk);
        chk("ov_drop.err", err_overflow_o, 1'b1); chk_wr("ov_drop", 16'h0300, 8'h21);
        ofmap_valid_i = 1'b0; glb_ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk_wr($sformatf("ov_drain%0d", k), 16'h0300 + 16'(k), 8'h21 + 8'(k));
        end
        @(negedge clk);
        chk("ov_empty.wr_en", glb_wr_en_o, 1'b0); chk("ov_sticky.err", err_overflow_o, 1'b1);
        push_row(8'h26);
        @(negedge clk); push_row(8'h27);
        @(negedge clk); ofmap_valid_i = 1'b0;
        chk_wr("ov_tail", 16'h0305, 8'h27);
        wait_done("ov");
        chk("ov_after_done.err", err_overflow_o, 1'b1);
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 16'h0400; glb_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        chk("ov_clear.err", err_overflow_o, 1'b0); chk("ov_clear.busy", busy_o, 1'b1);

        // Test 4: full buffer with simultaneous push and pop.
        push_row(8'h31);
        @(negedge clk); push_row(8'h32);
        @(negedge clk); push_row(8'h33);
        @(negedge clk); push_row(8'h34);
        @(negedge clk);
        chk("pp_full.stall", stall_o, 1'b1); chk_wr("pp_full", 16'h0400, 8'h31);
        glb_ready_i = 1'b1; push_row(8'h35);
        @(negedge clk);
        chk("pp.err", err_overflow_o, 1'b0); chk("pp.stall", stall_o, 1'b1);
        chk_wr("pp", 16'h0401, 8'h32);
        ofmap_valid_i = 1'b0;
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            chk_wr($sformatf("pp_drain%0d", k), 16'h0400 + 16'(k), 8'h31 + 8'(k));
        end
        @(negedge clk);
        chk("pp_empty.wr_en", glb_wr_en_o, 1'b0);
        push_row(8'h36);
        @(negedge clk);
        ofmap_valid_i = 1'b0;
        chk_wr("pp_last", 16'h0405, 8'h36);
        wait_done("pp");

        // Test 5a: address wrap from 0xFFFE.
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 16'hFFFE; glb_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; push_row(8'h41);
        @(negedge clk); chk_wr("wrap0", 16'hFFFE, 8'h41); push_row(8'h42);
        @(negedge clk); chk_wr("wrap1", 16'hFFFF, 8'h42); push_row(8'h43);
        @(negedge clk); chk_wr("wrap2", 16'h0000, 8'h43); push_row(8'h44);
        @(negedge clk); push_row(8'h45);
        @(negedge clk); push_row(8'h46);
        @(negedge clk); ofmap_valid_i = 1'b0;
        chk_wr("wrap5", 16'h0003, 8'h46);
        wait_done("wrap");
        @(negedge clk);
        chk("wrap_idle.busy", busy_o, 1'b0);

        chk("done_total", done_cnt, 4);
`ifdef OFMAP_WB_TILE_IRQ_EN
        chk("tile_total", tile_cnt, 9);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
